// File: rtl/parking_exit_controller.sv
// Parking exit controller: per-slot occupancy and billing-tick tracking,
// fee quote, payment handshake and timed exit gate.
// Optional grace period is compiled in when GRACE_PERIOD_EN is defined.

// Per-slot occupancy flag and saturating parked-duration counter.
module parking_slot #(
    parameter int DUR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             park,
    input  logic             free,
    output logic             occ,
    output logic [DUR_W-1:0] dur
);
    logic             occ_q, occ_d;
    logic [DUR_W-1:0] dur_q, dur_d;

    // Park wins over a simultaneous free; counter only runs while occupied.
    always_comb begin
        occ_d = occ_q;
        dur_d = dur_q;
        if (park) begin
            occ_d = 1'b1;
            dur_d = '0;
        end else if (free) begin
            occ_d = 1'b0;
            dur_d = '0;
        end else if (tick && occ_q && (dur_q != {DUR_W{1'b1}})) begin
            dur_d = dur_q + 1'b1;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= 1'b0;
            dur_q <= '0;
        end else begin
            occ_q <= occ_d;
            dur_q <= dur_d;
        end
    end

    assign occ = occ_q;
    assign dur = dur_q;
endmodule

module parking_exit_controller #(
    parameter int NUM_SLOTS   = 10,
    parameter int TICK_DIV    = 1000,
    parameter int RATE        = 2,
    parameter int DUR_W       = 10,
    parameter int FEE_W       = 12,
    parameter int GATE_CYCLES = 5,
`ifdef GRACE_PERIOD_EN
    parameter int GRACE_TICKS = 3,
`endif
    parameter int PAY_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 park_valid,
    input  logic [3:0]           park_slot,
    input  logic                 exit_req,
    input  logic [3:0]           exit_slot,
    input  logic                 pay_valid,
    input  logic [FEE_W-1:0]     pay_amount,
    output logic                 fee_valid,
    output logic [FEE_W-1:0]     fee_amount,
    output logic                 change_valid,
    output logic [FEE_W-1:0]     change_amount,
    output logic                 gate,
    output logic                 ERROR_slot,
    output logic                 ERROR_payment,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [3:0]           space_remaining
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(PAY_TIMEOUT + 1);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [63:0] FEE_MAX = (64'd1 << FEE_W) - 64'd1;

    typedef enum logic [1:0] {IDLE, QUOTE, GATE} state_t;

    state_t                          state_q, state_d;
    logic [PW-1:0]                   presc_q, presc_d;
    logic [TW-1:0]                   tmo_q, tmo_d;
    logic [GW-1:0]                   gcnt_q, gcnt_d;
    logic [3:0]                      slot_q, slot_d;
    logic [FEE_W-1:0]                fee_q, fee_d;
    logic [FEE_W-1:0]                chg_q, chg_d;
    logic                            chg_vld_q, chg_vld_d;
    logic                            err_slot_q, err_slot_d;
    logic                            err_pay_q, err_pay_d;
    logic [3:0]                      space_q, space_d;

    logic                            tick;
    logic                            accept;
    logic                            exit_ok;
    logic [DUR_W-1:0]                sel_dur;
    logic [63:0]                     fee_wide;
    logic [FEE_W-1:0]                fee_new;
    logic [NUM_SLOTS-1:0]            occ;
    logic [NUM_SLOTS-1:0]            park_vec, free_vec;
    logic [NUM_SLOTS-1:0][DUR_W-1:0] dur;

    assign tick   = (presc_q == PW'(TICK_DIV - 1));
    assign accept = (state_q == QUOTE) && pay_valid && (pay_amount >= fee_q);

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
            assign free_vec[k] = accept && (slot_q == 4'(k + 1));
            assign park_vec[k] = park_valid && (park_slot == 4'(k + 1)) &&
                                 (!occ[k] || free_vec[k]);
            parking_slot #(.DUR_W(DUR_W)) u_slot (
                .clk   (clk),
                .reset (reset),
                .tick  (tick),
                .park  (park_vec[k]),
                .free  (free_vec[k]),
                .occ   (occ[k]),
                .dur   (dur[k])
            );
        end
    endgenerate

    // Free-running billing prescaler.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Look up the requested slot and compute its saturated fee.
    always_comb begin
        exit_ok = 1'b0;
        sel_dur = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (exit_slot == 4'(i + 1)) begin
                exit_ok = occ[i];
                sel_dur = dur[i];
            end
        end
`ifdef GRACE_PERIOD_EN
        if (64'(sel_dur) < 64'(GRACE_TICKS))
            fee_wide = 64'd0;
        else
            fee_wide = (64'(sel_dur) - 64'(GRACE_TICKS) + 64'd1) * 64'(RATE);
`else
        fee_wide = (64'(sel_dur) + 64'd1) * 64'(RATE);
`endif
        fee_new = (fee_wide > FEE_MAX) ? FEE_MAX[FEE_W-1:0] : fee_wide[FEE_W-1:0];
    end

    // Exit FSM: quote, payment handshake, timed gate.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        gcnt_d     = gcnt_q;
        slot_d     = slot_q;
        fee_d      = fee_q;
        chg_d      = chg_q;
        chg_vld_d  = 1'b0;
        err_slot_d = 1'b0;
        err_pay_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    if (exit_ok) begin
                        slot_d  = exit_slot;
                        fee_d   = fee_new;
                        tmo_d   = '0;
                        state_d = QUOTE;
                    end else begin
                        err_slot_d = 1'b1;
                    end
                end
            end
            QUOTE: begin
                if (accept) begin
                    chg_vld_d = 1'b1;
                    chg_d     = pay_amount - fee_q;
                    gcnt_d    = '0;
                    state_d   = GATE;
                end else begin
                    if (pay_valid)
                        err_pay_d = 1'b1;
                    if (tmo_q == TW'(PAY_TIMEOUT - 1)) begin
                        err_pay_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            GATE: begin
                if (gcnt_q == GW'(GATE_CYCLES - 1))
                    state_d = IDLE;
                else
                    gcnt_d = gcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-space count lags occupancy by one cycle.
    always_comb begin
        int pc;
        pc = 0;
        for (int i = 0; i < NUM_SLOTS; i++)
            pc = pc + int'(occ[i]);
        space_d = 4'(NUM_SLOTS - pc);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            tmo_q      <= '0;
            gcnt_q     <= '0;
            slot_q     <= '0;
            fee_q      <= '0;
            chg_q      <= '0;
            chg_vld_q  <= 1'b0;
            err_slot_q <= 1'b0;
            err_pay_q  <= 1'b0;
            space_q    <= 4'(NUM_SLOTS);
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tmo_q      <= tmo_d;
            gcnt_q     <= gcnt_d;
            slot_q     <= slot_d;
            fee_q      <= fee_d;
            chg_q      <= chg_d;
            chg_vld_q  <= chg_vld_d;
            err_slot_q <= err_slot_d;
            err_pay_q  <= err_pay_d;
            space_q    <= space_d;
        end
    end

    assign fee_valid       = (state_q == QUOTE);
    assign fee_amount      = fee_q;
    assign change_valid    = chg_vld_q;
    assign change_amount   = chg_q;
    assign gate            = (state_q == GATE);
    assign ERROR_slot      = err_slot_q;
    assign ERROR_payment   = err_pay_q;
    assign occupied        = occ;
    assign space_remaining = space_q;
endmodule

// File: doc/parking_exit_controller.md
Name: parking_exit_controller

Overview:
- Exit-side counterpart to the entry/gate controller.
- Entry side reports each slot it fills; this block tracks occupancy and parked duration per slot.
- On an exit request it quotes a fee, runs a payment handshake, opens the exit gate for a fixed time, then frees the slot.
- Drives the space_remaining count back to the entry side.

Parameters:
- NUM_SLOTS, 10, number of parking slots; slots numbered 1..NUM_SLOTS.
- TICK_DIV, 1000, clock cycles per billing tick.
- RATE, 2, fee units charged per tick.
- DUR_W, 10, width of each per-slot tick counter (saturating).
- FEE_W, 12, width of fee, payment and change values.
- GATE_CYCLES, 5, cycles the gate stays open.
- PAY_TIMEOUT, 255, cycles in QUOTE without a sufficient payment before abort.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- park_valid, input, 1, one-cycle pulse: entry side has filled park_slot.
- park_slot, input, 4, slot filled (1-based).
- exit_req, input, 1, car at exit requests departure from exit_slot.
- exit_slot, input, 4, slot being vacated (1-based).
- pay_valid, input, 1, one-cycle pulse: payment presented.
- pay_amount, input, FEE_W, payment value.
- fee_valid, output, 1, high throughout QUOTE.
- fee_amount, output, FEE_W, quoted fee; stable while fee_valid.
- change_valid, output, 1, one-cycle pulse on accepted payment.
- change_amount, output, FEE_W, pay_amount minus fee; valid with change_valid.
- gate, output, 1, exit gate open.
- ERROR_slot, output, 1, one-cycle pulse: bad exit request.
- ERROR_payment, output, 1, one-cycle pulse: underpayment or timeout.
- occupied, output, NUM_SLOTS, bit k-1 set when slot k is occupied.
- space_remaining, output, 4, NUM_SLOTS minus popcount(occupied), registered.

Behaviour:
- Reset (async, immediate): all outputs 0 except space_remaining=NUM_SLOTS; occupied=0; all duration counters 0; prescaler 0; state IDLE.
- Prescaler:
  - Free-running, counts 0..TICK_DIV-1.
  - Tick pulse when it wraps to 0; first tick occurs TICK_DIV cycles after reset release.
  - On each tick, every occupied slot's counter increments, saturating at 2^DUR_W-1.
- Parking:
  - park_valid with park_slot in 1..NUM_SLOTS and slot free: set occupied bit and clear its counter.
  - park_valid on an occupied slot, slot 0, or slot >NUM_SLOTS: ignored.
  - Park and free of the same slot in the same cycle: park wins (bit set, counter 0).
- FSM states: IDLE, QUOTE, GATE.
- IDLE:
  - exit_req with exit_slot not in 1..NUM_SLOTS, or slot not occupied: ERROR_slot pulses next cycle; stay IDLE.
  - Valid exit_req: latch slot; fee=(ticks+1)*RATE, saturated to 2^FEE_W-1; registered into fee_amount; enter QUOTE. fee_valid is high the cycle after exit_req is sampled.
- QUOTE:
  - Timeout counter starts at 0 on entry.
  - pay_valid with pay_amount>=fee: change_valid pulse with change_amount=pay_amount-fee; clear slot occupancy and counter; enter GATE.
  - pay_valid with pay_amount<fee: ERROR_payment pulse; stay in QUOTE; timeout counter is not reset.
  - Timeout reaching PAY_TIMEOUT: ERROR_payment pulse; return to IDLE; slot stays occupied and its counter keeps running.
  - exit_req is ignored.
  - The slot counter keeps running during QUOTE, but the quoted fee is frozen.
- GATE:
  - gate=1 for exactly GATE_CYCLES cycles, then IDLE with gate=0.
  - exit_req and pay_valid are ignored.
- space_remaining updates one cycle after an occupied change.
- Reset mid-operation: gate drops immediately; all quote and payment state is lost.

Optional Feature:
- Macro: GRACE_PERIOD_EN.
- Defined:
  - Adds parameter GRACE_TICKS (default 3).
  - If ticks < GRACE_TICKS, fee=0 and QUOTE still asserts fee_valid.
  - Any pay_valid (including amount 0) is accepted, with change_amount=pay_amount.
  - Otherwise fee=(ticks-GRACE_TICKS+1)*RATE.
- Not defined: fee is always (ticks+1)*RATE; no grace logic is synthesized.

Test Plan (bench overrides TICK_DIV=4, RATE=2, GATE_CYCLES=5, PAY_TIMEOUT=20):
- Reset asserted mid-run -> gate=0, fee_valid=0, occupied=0, space_remaining=10 immediately; held after release.
- park slot 3 in the first cycle after reset release; exit_req slot 3 after 3 ticks (cycle 13) -> next cycle fee_valid=1, fee_amount=8; occupied=0x004; space_remaining=9.
- exit_req slot 0, slot 11, then unoccupied slot 5 -> three ERROR_slot pulses, fee_valid stays 0, state IDLE.
- In QUOTE with fee 8: pay 6 -> ERROR_payment pulse, still QUOTE. Then pay 10 -> change_valid with change_amount=2; gate high 5 cycles; occupied bit 2 clears; space_remaining=10.
- QUOTE with no payment for 20 cycles -> ERROR_payment pulse, IDLE, slot still occupied. A re-request quotes a higher fee.
- GRACE_PERIOD_EN defined, GRACE_TICKS=3: exit after 1 tick -> fee 0, pay 0 accepted, gate opens. Exit after 5 ticks -> fee 6.
